vga_layer_scheduler: RTL and testbench

- Per-pixel arbiter and frame-synchronous configuration controller in front of the VGA driver's colour inputs.
- Shares the driver's red/green/blue_color and drive_enable inputs between three pixel-layer requesters (digits, colon, background art) using fixed priority.
- Adds per-layer enable and blink.
- Config writes are shadowed and committed only at frame start, so no tearing.

---
 rtl/vga_layer_scheduler.sv | 255 +++++++++++++++++++++++++
 tb/tb_vga_layer_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_scheduler.sv
// -----------------------------------------------------------------------------
// vga_layer_scheduler
//
// Per-pixel arbiter and frame-synchronous configuration controller that sits
// in front of the VGA driver's colour inputs. Three pixel-layer requesters
// (digits = layer 0, colon = layer 1, background art = layer 2) share the
// driver's red/green/blue_color and drive_enable inputs. Layer 0 has the
// highest priority. Each layer can be enabled and blinked. Config writes go to
// shadow registers and are committed only at frame start, so a frame is never
// drawn with a half-updated configuration.
//
// Optional feature (macro VGA_SCHED_COLLISION_CNT_EN): a per-frame count of
// visible pixels where two or more enabled layers requested at once. With the
// macro undefined, collision_count is tied to 0 and no counter is built.
//
// Ports:
//   clock_100mhz     system clock
//   reset_n          asynchronous active-low reset
//   Hcnt, Vcnt       horizontal/vertical counters from the VGA driver
//   layer_req[2:0]   per-layer pixel request, bit 0 highest priority
//   layer_color[35:0]{l2,l1,l0} RGB444 colours, l0 in [11:0]
//   cfg_wr           config write strobe (one clock)
//   cfg_addr[1:0]    config register select
//   cfg_data[11:0]   config write data
//   red/green/blue_color  4-bit colour to the driver
//   drive_enable     colour-drive enable to the driver
//   grant[2:0]       one-hot winning layer, 0 when background or blanked
//   frame_start      one-clock pulse when Vcnt wraps to 0
//   collision_count  collisions counted in the previous frame
//
// Config map:
//   addr0: [11:0] background colour
//   addr1: [2:0] layer_en, [3] master_en
//   addr2: [2:0] blink_mask
//   addr3: [5:0] blink_period in frames (0 = no blinking)
//
// Config port protocol: there is no ready; the block accepts a write on every
// clock where cfg_wr is high. A write landing on the frame_start clock is
// forwarded straight into that frame's commit.
// -----------------------------------------------------------------------------
module vga_layer_scheduler #(
  parameter int HDISP_ON  = 144,
  parameter int HDISP_OFF = 784,
  parameter int VDISP_ON  = 35,
  parameter int VDISP_OFF = 514,
  parameter int CNT_W     = 16
) (
  input  logic             clock_100mhz,
  input  logic             reset_n,
  input  logic [9:0]       Hcnt,
  input  logic [9:0]       Vcnt,
  input  logic [2:0]       layer_req,
  input  logic [35:0]      layer_color,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_addr,
  input  logic [11:0]      cfg_data,
  output logic [3:0]       red_color,
  output logic [3:0]       green_color,
  output logic [3:0]       blue_color,
  output logic             drive_enable,
  output logic [2:0]       grant,
  output logic             frame_start,
  output logic [CNT_W-1:0] collision_count
);

  localparam logic [9:0] H_ON  = 10'(HDISP_ON);
  localparam logic [9:0] H_OFF = 10'(HDISP_OFF);
  localparam logic [9:0] V_ON  = 10'(VDISP_ON);
  localparam logic [9:0] V_OFF = 10'(VDISP_OFF);

  // ---------------------------------------------------------------------------
  // Pixel strobe and frame start from the driver counters
  // ---------------------------------------------------------------------------
  logic [9:0] h_q;
  logic [9:0] v_q;
  logic       pix_stb;

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= 10'd0;
      v_q <= 10'd0;
    end else begin
      h_q <= Hcnt;
      v_q <= Vcnt;
    end
  end

  // A new pixel is whatever clock sees Hcnt differ from last clock.
  assign pix_stb = (Hcnt != h_q);
  // Fires only on the wrap into Vcnt==0; v_q is 0 for the rest of that line.
  assign frame_start = (v_q != 10'd0) && (Vcnt == 10'd0);

  // ---------------------------------------------------------------------------
  // Shadow / active configuration
  // ---------------------------------------------------------------------------
  logic [11:0] sh_bg,     sh_bg_n,     act_bg;
  logic [2:0]  sh_en,     sh_en_n,     act_en;
  logic        sh_master, sh_master_n, act_master;
  logic [2:0]  sh_mask,   sh_mask_n,   act_mask;
  logic [5:0]  sh_period, sh_period_n;

  // Next shadow value includes this clock's write, so a write on the
  // frame_start clock is committed in the same frame.
  always_comb begin
    sh_bg_n     = sh_bg;
    sh_en_n     = sh_en;
    sh_master_n = sh_master;
    sh_mask_n   = sh_mask;
    sh_period_n = sh_period;
    if (cfg_wr) begin
      case (cfg_addr)
        2'd0: sh_bg_n = cfg_data;
        2'd1: begin
          sh_en_n     = cfg_data[2:0];
          sh_master_n = cfg_data[3];
        end
        2'd2: sh_mask_n   = cfg_data[2:0];
        default: sh_period_n = cfg_data[5:0];
      endcase
    end
  end

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      sh_bg      <= 12'h000;
      sh_en      <= 3'b111;
      sh_master  <= 1'b1;
      sh_mask    <= 3'b000;
      sh_period  <= 6'd0;
      act_bg     <= 12'h000;
      act_en     <= 3'b111;
      act_master <= 1'b1;
      act_mask   <= 3'b000;
    end else begin
      sh_bg     <= sh_bg_n;
      sh_en     <= sh_en_n;
      sh_master <= sh_master_n;
      sh_mask   <= sh_mask_n;
      sh_period <= sh_period_n;
      if (frame_start) begin
        act_bg     <= sh_bg_n;
        act_en     <= sh_en_n;
        act_master <= sh_master_n;
        act_mask   <= sh_mask_n;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Blink timing: advances on frame_start using the period being committed
  // on that same clock, so there is no separate active copy of the period.
  // ---------------------------------------------------------------------------
  logic [5:0] frame_cnt;
  logic       blink_phase;

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt   <= 6'd0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (sh_period_n == 6'd0) begin
        frame_cnt   <= 6'd0;
        blink_phase <= 1'b1;
      end else if (frame_cnt == sh_period_n - 6'd1) begin
        frame_cnt   <= 6'd0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [2:0]  eligible;
  logic [2:0]  win_grant;
  logic [11:0] win_color;
  logic        visible;

  assign eligible = layer_req & act_en & ~(act_mask & {3{~blink_phase}});
  assign visible  = (Hcnt >= H_ON) && (Hcnt <= H_OFF) &&
                    (Vcnt >= V_ON) && (Vcnt <= V_OFF);

  always_comb begin
    win_grant = 3'b000;
    win_color = act_bg;
    if (eligible[0]) begin
      win_grant = 3'b001;
      win_color = layer_color[11:0];
    end else if (eligible[1]) begin
      win_grant = 3'b010;
      win_color = layer_color[23:12];
    end else if (eligible[2]) begin
      win_grant = 3'b100;
      win_color = layer_color[35:24];
    end
  end

  // Outputs are registered and change only on the clock after a pixel strobe.
  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      red_color    <= 4'h0;
      green_color  <= 4'h0;
      blue_color   <= 4'h0;
      drive_enable <= 1'b0;
      grant        <= 3'b000;
    end else if (pix_stb) begin
      if (visible && act_master) begin
        red_color    <= win_color[11:8];
        green_color  <= win_color[7:4];
        blue_color   <= win_color[3:0];
        drive_enable <= 1'b1;
        grant        <= win_grant;
      end else begin
        red_color    <= 4'h0;
        green_color  <= 4'h0;
        blue_color   <= 4'h0;
        drive_enable <= 1'b0;
        grant        <= 3'b000;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional collision counter
  // ---------------------------------------------------------------------------
`ifdef VGA_SCHED_COLLISION_CNT_EN
  logic [2:0]       en_req;
  logic             coll_hit;
  logic [CNT_W-1:0] coll_q;
  logic [CNT_W-1:0] coll_out_q;

  assign en_req = layer_req & act_en;
  // Clearing the lowest set bit leaves a non-zero value iff two or more set.
  assign coll_hit = pix_stb && visible && ((en_req & (en_req - 3'd1)) != 3'd0);

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      coll_q     <= '0;
      coll_out_q <= '0;
    end else if (frame_start) begin
      coll_out_q <= coll_q;
      coll_q     <= coll_hit ? CNT_W'(1) : '0;
    end else if (coll_hit && (coll_q != {CNT_W{1'b1}})) begin
      coll_q <= coll_q + CNT_W'(1);
    end
  end

  assign collision_count = coll_out_q;
`else
  assign collision_count = '0;
`endif

endmodule

// File: tb/tb_vga_layer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vga_layer_scheduler
//
// Directed bench for vga_layer_scheduler. Hcnt/Vcnt are driven directly to the
// coordinates of interest (the block only reacts to changes of Hcnt and to the
// wrap of Vcnt to 0), with four clocks between pixels. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_vga_layer_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  Hcnt;
  logic [9:0]  Vcnt;
  logic [2:0]  layer_req;
  logic [35:0] layer_color;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic [3:0]  red_color;
  logic [3:0]  green_color;
  logic [3:0]  blue_color;
  logic        drive_enable;
  logic [2:0]  grant;
  logic        frame_start;
  logic [15:0] collision_count;

  int checks   = 0;
  int failures = 0;

  // Expected frame-by-frame visibility of layer 0 in the blink test.
  logic [5:0] blink_vis = 6'b110011;

  vga_layer_scheduler dut (
    .clock_100mhz    (clk),
    .reset_n         (reset_n),
    .Hcnt            (Hcnt),
    .Vcnt            (Vcnt),
    .layer_req       (layer_req),
    .layer_color     (layer_color),
    .cfg_wr          (cfg_wr),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .red_color       (red_color),
    .green_color     (green_color),
    .blue_color      (blue_color),
    .drive_enable    (drive_enable),
    .grant           (grant),
    .frame_start     (frame_start),
    .collision_count (collision_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checker and driver tasks
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [11:0] exp_rgb,
                         input logic [2:0] exp_grant, input logic exp_de);
    chk({tag, ".rgb"},   {4'h0, red_color, green_color, blue_color}, {4'h0, exp_rgb});
    chk({tag, ".grant"}, {13'h0, grant}, {13'h0, exp_grant});
    chk({tag, ".de"},    {15'h0, drive_enable}, {15'h0, exp_de});
  endtask

  // Move to a new pixel; returns one clock (+1) after the counter change.
  task automatic pix(input logic [9:0] h, input logic [9:0] v);
    repeat (3) @(posedge clk);
    @(negedge clk);
    Hcnt = h;
    Vcnt = v;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [11:0] d);
    @(negedge clk);
    cfg_wr   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_wr   = 1'b0;
  endtask

  // Wrap Vcnt to 0, optionally with a config write on the frame_start clock.
  task automatic new_frame(input logic wr, input logic [1:0] a, input logic [11:0] d);
    @(negedge clk);
    Hcnt     = 10'd0;
    Vcnt     = 10'd0;
    cfg_wr   = wr;
    cfg_addr = a;
    cfg_data = d;
    #1;
    chk("frame_start_pulse", {15'h0, frame_start}, 16'h0001);
    @(posedge clk);
    #1;
    chk("frame_start_single", {15'h0, frame_start}, 16'h0000);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset_n     = 1'b0;
    Hcnt        = 10'd0;
    Vcnt        = 10'd0;
    layer_req   = 3'b000;
    layer_color = 36'h0;
    cfg_wr      = 1'b0;
    cfg_addr    = 2'd0;
    cfg_data    = 12'h000;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk_out("reset", 12'h000, 3'b000, 1'b0);
    chk("reset.fs", {15'h0, frame_start}, 16'h0000);
    chk("reset.cc", collision_count, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle: blanked until the first visible pixel, then background
    pix(10'd100, 10'd35);
    chk_out("idle_h100", 12'h000, 3'b000, 1'b0);
    pix(10'd144, 10'd34);
    chk_out("idle_v34", 12'h000, 3'b000, 1'b0);
    pix(10'd143, 10'd35);
    chk_out("idle_h143", 12'h000, 3'b000, 1'b0);
    pix(10'd144, 10'd35);
    chk_out("first_visible", 12'h000, 3'b000, 1'b1);

    // Priority
    layer_color = {12'h0F0, 12'hF00, 12'h000};
    layer_req   = 3'b110;
    pix(10'd145, 10'd35);
    chk_out("prio_110", 12'hF00, 3'b010, 1'b1);
    // No Hcnt change: outputs must hold even though the request changed
    layer_req = 3'b001;
    repeat (2) @(posedge clk);
    #1;
    chk_out("hold_no_stb", 12'hF00, 3'b010, 1'b1);
    layer_req   = 3'b111;
    layer_color = {12'h0F0, 12'hF00, 12'h00F};
    pix(10'd146, 10'd35);
    chk_out("prio_111", 12'h00F, 3'b001, 1'b1);

    // Blanking boundaries
    pix(10'd784, 10'd35);
    chk_out("h784", 12'h00F, 3'b001, 1'b1);
    pix(10'd785, 10'd35);
    chk_out("h785", 12'h000, 3'b000, 1'b0);
    pix(10'd784, 10'd515);
    chk_out("v515", 12'h000, 3'b000, 1'b0);
    pix(10'd783, 10'd514);
    chk_out("v514", 12'h00F, 3'b001, 1'b1);
    pix(10'd143, 10'd100);
    chk_out("h143", 12'h000, 3'b000, 1'b0);

    // Shadowed config: master off, layer_en=110, written mid-frame
    cfg_write(2'd1, 12'h006);
    pix(10'd200, 10'd100);
    chk_out("shadow_pending", 12'h00F, 3'b001, 1'b1);
    new_frame(1'b0, 2'd0, 12'h000);
    pix(10'd5, 10'd0);
    chk("no_refire", {15'h0, frame_start}, 16'h0000);
    pix(10'd200, 10'd100);
    chk_out("master_off", 12'h000, 3'b000, 1'b0);
    // Write on the frame_start clock: master on, layer_en=110
    new_frame(1'b1, 2'd1, 12'h00E);
    pix(10'd300, 10'd200);
    chk_out("fs_forward", 12'hF00, 3'b010, 1'b1);

    // Background colour, committed with layer_en=111 forwarded at frame start
    cfg_write(2'd0, 12'h0AB);
    layer_req = 3'b000;
    pix(10'd301, 10'd200);
    chk_out("bg_pending", 12'h000, 3'b000, 1'b1);
    new_frame(1'b1, 2'd1, 12'h00F);
    pix(10'd302, 10'd200);
    chk_out("bg_active", 12'h0AB, 3'b000, 1'b1);

    // Blink: period 2, mask 001; frame 0 is the frame the writes happen in
    cfg_write(2'd2, 12'h001);
    cfg_write(2'd3, 12'h002);
    layer_req = 3'b001;
    pix(10'd310, 10'd100);
    chk_out("blink_f0", 12'h00F, 3'b001, 1'b1);
    for (int f = 1; f < 6; f++) begin
      new_frame(1'b0, 2'd0, 12'h000);
      pix(10'(310 + f), 10'd100);
      if (blink_vis[f])
        chk_out($sformatf("blink_f%0d", f), 12'h00F, 3'b001, 1'b1);
      else
        chk_out($sformatf("blink_f%0d", f), 12'h0AB, 3'b000, 1'b1);
    end
    cfg_write(2'd2, 12'h000);
    cfg_write(2'd3, 12'h000);
    new_frame(1'b0, 2'd0, 12'h000);

    // Collisions: 10 visible pixels with req=011, plus non-counting pixels
    layer_req = 3'b011;
    for (int i = 0; i < 10; i++) begin
      pix(10'(150 + i), 10'd100);
    end
    chk_out("coll_grant", 12'h00F, 3'b001, 1'b1);
    pix(10'd10, 10'd100);
    pix(10'd11, 10'd100);
    layer_req = 3'b001;
    pix(10'd400, 10'd100);
    new_frame(1'b0, 2'd0, 12'h000);
`ifdef VGA_SCHED_COLLISION_CNT_EN
    chk("coll_count10", collision_count, 16'd10);
`else
    chk("coll_count_off", collision_count, 16'd0);
`endif
    layer_req = 3'b000;
    pix(10'd401, 10'd100);
    new_frame(1'b0, 2'd0, 12'h000);
    chk("coll_count0", collision_count, 16'd0);

    // Mid-frame reset: outputs clear immediately, config back to defaults
    layer_req = 3'b111;
    pix(10'd500, 10'd300);
    chk_out("pre_reset", 12'h00F, 3'b001, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_out("async_reset", 12'h000, 3'b000, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    layer_req = 3'b000;
    pix(10'd501, 10'd300);
    chk_out("post_reset_bg", 12'h000, 3'b000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
